// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage (forwarding, ALU, branch/jump resolve); `EX_STAGE_MULDIV_EN adds RV32M mul + iterative divider
module ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] E_RD1,
    input  logic [31:0] E_RD2,
    input  logic [31:0] E_ImmExt,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_PCPlus4,
    input  logic        E_ALUSrc,
    input  logic        E_Branch,
    input  logic        E_Jump,
    input  logic        E_JumpReg,
    input  logic        E_MulDiv,
    input  logic [3:0]  E_ALUControl,
    input  logic [2:0]  E_funct3,
    input  logic [1:0]  E_ForwardA,
    input  logic [1:0]  E_ForwardB,
    input  logic [31:0] M_ALUResult,
    input  logic [31:0] W_Result,
    output logic [31:0] E_ALUResult,
    output logic [31:0] E_WriteData,
    output logic [31:0] E_PCTarget,
    output logic        E_PCSrc,
    output logic        E_Stall
);
    logic [31:0] src_a, src_b, alu_res, md_res;
    logic        cond;
    assign src_a = (E_ForwardA == 2'b01) ? W_Result : (E_ForwardA == 2'b10) ? M_ALUResult : E_RD1;
    assign E_WriteData = (E_ForwardB == 2'b01) ? W_Result : (E_ForwardB == 2'b10) ? M_ALUResult : E_RD2;
    assign src_b = E_ALUSrc ? E_ImmExt : E_WriteData;
    always_comb begin
        case (E_ALUControl)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a ^ src_b;
            4'b0101: alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            4'b0110: alu_res = {31'd0, src_a < src_b};
            4'b0111: alu_res = src_a << src_b[4:0];
            4'b1000: alu_res = src_a >> src_b[4:0];
            4'b1001: alu_res = $signed(src_a) >>> src_b[4:0];
            4'b1010: alu_res = src_b;
            default: alu_res = '0;
        endcase
    end
    always_comb begin
        case (E_funct3)
            3'b000:  cond = src_a == E_WriteData;
            3'b001:  cond = src_a != E_WriteData;
            3'b100:  cond = $signed(src_a) < $signed(E_WriteData);
            3'b101:  cond = $signed(src_a) >= $signed(E_WriteData);
            3'b110:  cond = src_a < E_WriteData;
            3'b111:  cond = src_a >= E_WriteData;
            default: cond = 1'b0;
        endcase
    end
    assign E_PCSrc     = E_Jump | (E_Branch & cond);
    assign E_PCTarget  = E_JumpReg ? ((src_a + E_ImmExt) & ~32'd1) : E_PC + E_ImmExt;
    assign E_ALUResult = E_Jump ? E_PCPlus4 : E_MulDiv ? md_res : alu_res;
`ifdef EX_STAGE_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q, state_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        negq_q, negq_d, negr_q, negr_d, isrem_q, isrem_d;
    logic [63:0] prod;
    logic [32:0] trial;
    logic [31:0] a_abs, b_abs, q_out, r_out, spec_res;
    logic        sgn, a_neg, b_neg, is_div, div0, ovf, stall;
    assign prod  = {{32{(E_funct3[1:0] != 2'b11) & src_a[31]}}, src_a}
                 * {{32{(E_funct3[1:0] == 2'b01) & src_b[31]}}, src_b};
    assign sgn   = ~E_funct3[0];
    assign a_neg = sgn & src_a[31];
    assign b_neg = sgn & src_b[31];
    assign a_abs = a_neg ? -src_a : src_a;
    assign b_abs = b_neg ? -src_b : src_b;
    assign is_div = E_MulDiv & E_funct3[2];
    assign div0  = src_b == '0;
    assign ovf   = sgn & (src_a == 32'h8000_0000) & (src_b == 32'hFFFF_FFFF);
    assign spec_res = div0 ? (E_funct3[1] ? src_a : 32'hFFFF_FFFF) : (E_funct3[1] ? 32'd0 : 32'h8000_0000);
    // Restoring step: shift next dividend bit into the partial remainder and try to subtract.
    assign trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    assign q_out = negq_q ? -quo_q : quo_q;
    assign r_out = negr_q ? -rem_q : rem_q;
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        isrem_d = isrem_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: if (is_div && !div0 && !ovf) begin
                state_d = BUSY;
                stall   = 1'b1;
                rem_d   = '0;
                quo_d   = a_abs;
                dvs_d   = b_abs;
                cnt_d   = '0;
                negq_d  = a_neg ^ b_neg;
                negr_d  = a_neg;
                isrem_d = E_funct3[1];
            end
            BUSY: begin
                stall   = 1'b1;
                quo_d   = {quo_q[30:0], ~trial[32]};
                rem_d   = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q == 5'd31) ? DONE : BUSY;
            end
            default: state_d = IDLE;
        endcase
    end
    assign md_res = !E_funct3[2] ? ((E_funct3[1:0] == 2'b00) ? prod[31:0] : prod[63:32])
                  : (state_q == DONE) ? (isrem_q ? r_out : q_out)
                  : (div0 | ovf) ? spec_res : 32'd0;
    assign E_Stall = rst_n & stall;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            isrem_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            isrem_q <= isrem_d;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign md_res  = '0;
    assign E_Stall = 1'b0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] E_RD1, E_RD2, E_ImmExt, E_PC, E_PCPlus4, M_ALUResult, W_Result;
    logic        E_ALUSrc, E_Branch, E_Jump, E_JumpReg, E_MulDiv;
    logic [3:0]  E_ALUControl;
    logic [2:0]  E_funct3;
    logic [1:0]  E_ForwardA, E_ForwardB;
    logic [31:0] E_ALUResult, E_WriteData, E_PCTarget;
    logic        E_PCSrc, E_Stall;
    int tests = 0;
    int fails = 0;

    ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .E_RD1(E_RD1), .E_RD2(E_RD2), .E_ImmExt(E_ImmExt),
        .E_PC(E_PC), .E_PCPlus4(E_PCPlus4),
        .E_ALUSrc(E_ALUSrc), .E_Branch(E_Branch), .E_Jump(E_Jump), .E_JumpReg(E_JumpReg), .E_MulDiv(E_MulDiv),
        .E_ALUControl(E_ALUControl), .E_funct3(E_funct3),
        .E_ForwardA(E_ForwardA), .E_ForwardB(E_ForwardB),
        .M_ALUResult(M_ALUResult), .W_Result(W_Result),
        .E_ALUResult(E_ALUResult), .E_WriteData(E_WriteData), .E_PCTarget(E_PCTarget),
        .E_PCSrc(E_PCSrc), .E_Stall(E_Stall)
    );

    always #5 clk = ~clk;

    task automatic clear();
        E_RD1 = 0; E_RD2 = 0; E_ImmExt = 0; E_PC = 0; E_PCPlus4 = 0;
        M_ALUResult = 0; W_Result = 0;
        E_ALUSrc = 0; E_Branch = 0; E_Jump = 0; E_JumpReg = 0; E_MulDiv = 0;
        E_ALUControl = 0; E_funct3 = 0; E_ForwardA = 0; E_ForwardB = 0;
    endtask

    task automatic test_reset();
        clear();
        rst_n = 1'b0;
        E_RD1 = 32'd3; E_RD2 = 32'd4;
        #1;
        tests++;
        if (E_Stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", E_Stall); end
        tests++;
        if (E_ALUResult !== 32'd7) begin fails++; $display("FAIL reset_comb_add got %h want 00000007", E_ALUResult); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear();
    endtask

    task automatic test_forwarding();
        clear();
        E_RD1 = 5; E_RD2 = 7; E_ForwardA = 2'b10; M_ALUResult = 100;
        #1 tests++;
        if (E_ALUResult !== 32'd107) begin fails++; $display("FAIL fwd_a_mem got %h want %h", E_ALUResult, 32'd107); end
        E_ForwardA = 2'b01; W_Result = 20;
        #1 tests++;
        if (E_ALUResult !== 32'd27) begin fails++; $display("FAIL fwd_a_wb got %h want %h", E_ALUResult, 32'd27); end
        E_ForwardA = 2'b11;
        #1 tests++;
        if (E_ALUResult !== 32'd12) begin fails++; $display("FAIL fwd_a_11 got %h want %h", E_ALUResult, 32'd12); end
        E_ForwardB = 2'b01;
        #1 tests++;
        if (E_WriteData !== 32'd20 || E_ALUResult !== 32'd25) begin
            fails++; $display("FAIL fwd_b_wb got wd=%h res=%h want 00000014/00000019", E_WriteData, E_ALUResult);
        end
        E_ALUSrc = 1; E_ImmExt = 32'd1000;
        #1 tests++;
        if (E_ALUResult !== 32'd1005 || E_WriteData !== 32'd20) begin
            fails++; $display("FAIL alusrc_imm got res=%h wd=%h want 000003ed/00000014", E_ALUResult, E_WriteData);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0]  ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd15};
        logic [31:0] exp [13] = '{32'h80000014, 32'h8000000C, 32'h00000000, 32'h80000014, 32'h80000014,
                                  32'h00000001, 32'h00000000, 32'h00000100, 32'h08000001, 32'hF8000001,
                                  32'h00000004, 32'h00000000, 32'h00000000};
        clear();
        E_RD1 = 32'h80000010; E_RD2 = 32'h00000004;
        for (int i = 0; i < 13; i++) begin
            E_ALUControl = ops[i];
            #1 tests++;
            if (E_ALUResult !== exp[i]) begin
                fails++; $display("FAIL alu_op_%0d got %h want %h", ops[i], E_ALUResult, exp[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic exp [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        clear();
        E_RD1 = 32'hFFFFFFFF; E_RD2 = 32'd1; E_PC = 32'h100; E_ImmExt = 32'h20; E_ALUSrc = 1; E_Branch = 1;
        for (int i = 0; i < 8; i++) begin
            E_funct3 = 3'(i);
            #1 tests++;
            if (E_PCSrc !== exp[i] || E_PCTarget !== 32'h120) begin
                fails++; $display("FAIL branch_f3_%0d got pcsrc=%b tgt=%h want %b/00000120", i, E_PCSrc, E_PCTarget, exp[i]);
            end
        end
        E_RD1 = 32'd5; E_RD2 = 32'd5; E_funct3 = 3'b000;
        #1 tests++;
        if (E_PCSrc !== 1'b1) begin fails++; $display("FAIL beq_equal got %b want 1", E_PCSrc); end
        E_funct3 = 3'b101;
        #1 tests++;
        if (E_PCSrc !== 1'b1) begin fails++; $display("FAIL bge_equal got %b want 1", E_PCSrc); end
        E_Branch = 0;
        #1 tests++;
        if (E_PCSrc !== 1'b0) begin fails++; $display("FAIL no_branch got %b want 0", E_PCSrc); end
    endtask

    task automatic test_jump();
        clear();
        E_RD1 = 32'h1003; E_ImmExt = 32'd4; E_PCPlus4 = 32'h50; E_PC = 32'h4C; E_ALUSrc = 1;
        E_Jump = 1; E_JumpReg = 1; E_ALUControl = 4'd0;
        #1 tests++;
        if (E_PCTarget !== 32'h1006 || E_ALUResult !== 32'h50 || E_PCSrc !== 1'b1) begin
            fails++; $display("FAIL jalr got tgt=%h res=%h pcsrc=%b want 00001006/00000050/1", E_PCTarget, E_ALUResult, E_PCSrc);
        end
        E_JumpReg = 0; E_PC = 32'h200; E_ImmExt = 32'hFFFFFFF0; E_PCPlus4 = 32'h204;
        #1 tests++;
        if (E_PCTarget !== 32'h1F0 || E_ALUResult !== 32'h204 || E_PCSrc !== 1'b1) begin
            fails++; $display("FAIL jal got tgt=%h res=%h pcsrc=%b want 000001f0/00000204/1", E_PCTarget, E_ALUResult, E_PCSrc);
        end
        E_JumpReg = 1; E_RD1 = 32'hFFFFFFFF; E_ImmExt = 32'd3;
        #1 tests++;
        if (E_PCTarget !== 32'h2) begin fails++; $display("FAIL jalr_wrap got %h want 00000002", E_PCTarget); end
    endtask

`ifdef EX_STAGE_MULDIV_EN
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                           input logic [31:0] exp, input string name);
        int n = 0;
        E_MulDiv = 1; E_funct3 = f3; E_RD1 = a; E_RD2 = b; E_ALUSrc = 0; E_ForwardA = 0; E_ForwardB = 0; E_Jump = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!E_Stall) break;
            n++;
            if (n == 5) begin E_RD1 = ~a; E_RD2 = ~b; end
        end
        tests++;
        if (n !== 33) begin fails++; $display("FAIL %s_stall_cycles got %0d want 33", name, n); end
        tests++;
        if (E_ALUResult !== exp) begin fails++; $display("FAIL %s_result got %h want %h", name, E_ALUResult, exp); end
    endtask

    task automatic test_back_to_back();
        clear();
        @(posedge clk); #1;
        run_div(32'hFFFFFFF9, 32'd2, 3'b100, 32'hFFFFFFFD, "div_m7_2");
        run_div(32'hFFFFFFF9, 32'd2, 3'b110, 32'hFFFFFFFF, "rem_m7_2");
        E_MulDiv = 0;
    endtask

    task automatic test_special();
        clear();
        @(posedge clk); #1;
        E_MulDiv = 1; E_RD1 = 32'd10; E_RD2 = 32'd0; E_funct3 = 3'b101;
        #1 tests++;
        if (E_Stall !== 1'b0 || E_ALUResult !== 32'hFFFFFFFF) begin
            fails++; $display("FAIL divu_by0 got stall=%b res=%h want 0/ffffffff", E_Stall, E_ALUResult);
        end
        E_funct3 = 3'b111;
        #1 tests++;
        if (E_Stall !== 1'b0 || E_ALUResult !== 32'd10) begin
            fails++; $display("FAIL remu_by0 got stall=%b res=%h want 0/0000000a", E_Stall, E_ALUResult);
        end
        @(negedge clk);
        tests++;
        if (E_Stall !== 1'b0) begin fails++; $display("FAIL by0_no_start got %b want 0", E_Stall); end
        E_RD1 = 32'h80000000; E_RD2 = 32'hFFFFFFFF; E_funct3 = 3'b100;
        #1 tests++;
        if (E_Stall !== 1'b0 || E_ALUResult !== 32'h80000000) begin
            fails++; $display("FAIL div_ovf got stall=%b res=%h want 0/80000000", E_Stall, E_ALUResult);
        end
        E_funct3 = 3'b110;
        #1 tests++;
        if (E_ALUResult !== 32'd0) begin fails++; $display("FAIL rem_ovf got %h want 00000000", E_ALUResult); end
        E_RD2 = 32'd2; E_funct3 = 3'b001;
        #1 tests++;
        if (E_Stall !== 1'b0 || E_ALUResult !== 32'hFFFFFFFF) begin
            fails++; $display("FAIL mulh got stall=%b res=%h want 0/ffffffff", E_Stall, E_ALUResult);
        end
        E_funct3 = 3'b011;
        #1 tests++;
        if (E_ALUResult !== 32'd1) begin fails++; $display("FAIL mulhu got %h want 00000001", E_ALUResult); end
        E_RD1 = 32'hFFFFFFFF; E_RD2 = 32'hFFFFFFFF; E_funct3 = 3'b010;
        #1 tests++;
        if (E_ALUResult !== 32'hFFFFFFFF) begin fails++; $display("FAIL mulhsu got %h want ffffffff", E_ALUResult); end
        E_RD1 = 32'd12345; E_RD2 = 32'd1000; E_funct3 = 3'b000;
        #1 tests++;
        if (E_ALUResult !== 32'd12345000) begin fails++; $display("FAIL mul got %h want %h", E_ALUResult, 32'd12345000); end
        E_MulDiv = 0;
    endtask

    task automatic test_reset_mid_busy();
        clear();
        @(posedge clk); #1;
        E_MulDiv = 1; E_funct3 = 3'b101; E_RD1 = 32'd100; E_RD2 = 32'd7;
        repeat (11) @(negedge clk);
        tests++;
        if (E_Stall !== 1'b1) begin fails++; $display("FAIL busy_before_reset got %b want 1", E_Stall); end
        rst_n = 1'b0;
        #1 tests++;
        if (E_Stall !== 1'b0) begin fails++; $display("FAIL reset_mid_busy got %b want 0", E_Stall); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_div(32'd100, 32'd7, 3'b101, 32'd14, "divu_100_7");
        E_MulDiv = 0;
    endtask
`else
    task automatic test_muldiv_disabled();
        clear();
        @(posedge clk); #1;
        E_MulDiv = 1; E_funct3 = 3'b100; E_RD1 = 32'd7; E_RD2 = 32'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (E_Stall !== 1'b0 || E_ALUResult !== 32'd0) begin
                fails++; $display("FAIL muldiv_off_%0d got stall=%b res=%h want 0/00000000", i, E_Stall, E_ALUResult);
            end
        end
        E_funct3 = 3'b001;
        #1 tests++;
        if (E_ALUResult !== 32'd0) begin fails++; $display("FAIL mul_off got %h want 00000000", E_ALUResult); end
        E_MulDiv = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_alu_ops();
        test_branch();
        test_jump();
`ifdef EX_STAGE_MULDIV_EN
        test_back_to_back();
        test_special();
        test_reset_mid_busy();
`else
        test_muldiv_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have: clk  in  1  rising-edge clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: E_RD1, E_RD2, E_ImmExt  in  32  operands and immediate from the ID/EX register.
REQ-003 SHALL have: E_PC, E_PCPlus4  in  32  instruction PC and PC+4.
REQ-004 SHALL have: E_ALUSrc, E_Branch, E_Jump, E_JumpReg, E_MulDiv  in  1  each: immediate select, branch, JAL/JALR, JALR, RV32M op.
REQ-005 SHALL have: E_ALUControl  in  4  ALU op; E_funct3  in  3  branch condition or M-op select.
REQ-006 SHALL have: E_ForwardA, E_ForwardB  in  2  forwarding select (00 register, 01 W_Result, 10 M_ALUResult, 11 register).
REQ-007 SHALL have: M_ALUResult, W_Result  in  32  forwarded values.
REQ-008 SHALL have: E_ALUResult, E_WriteData, E_PCTarget  out  32  result, store data (forwarded B), redirect target.
REQ-009 SHALL have: E_PCSrc  out  1  redirect taken; E_Stall  out  1  hold IF/ID/EX while divider busy.

Function
REQ-010 SrcA SHALL be forwarded RD1; E_WriteData SHALL be forwarded RD2; SrcB SHALL be E_ImmExt if E_ALUSrc else E_WriteData.
REQ-011 ALU encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 pass SrcB; others produce 0; shifts use SrcB[4:0].
REQ-012 Branch condition on SrcA vs forwarded RD2 via funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 SHALL be not-taken.
REQ-013 E_PCSrc SHALL be E_Jump | (E_Branch & condition); combinational, same cycle.
REQ-014 E_PCTarget SHALL be (SrcA+E_ImmExt)&~1 when E_JumpReg, else E_PC+E_ImmExt, 32-bit wrap.
REQ-015 When E_Jump, E_ALUResult SHALL be E_PCPlus4.
REQ-016 When E_MulDiv, funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU SHALL complete combinationally in one cycle, no stall.
REQ-017 funct3 100 DIV, 101 DIVU, 110 REM, 111 REMU SHALL use a radix-2 restoring divider FSM: IDLE, BUSY, DONE.
REQ-018 IDLE: divide op present and not special case -> latch operands, sign flags, op; E_Stall=1 combinationally that cycle; go BUSY.
REQ-019 BUSY: one quotient bit per cycle, 32 cycles, E_Stall=1; after 32nd iteration go DONE.
REQ-020 DONE: E_Stall=0, E_ALUResult = sign-corrected quotient/remainder; next state IDLE unconditionally (no restart of the same op).
REQ-021 Total latency: stall high 33 cycles, result valid on 34th cycle of residency.
REQ-022 Divide by zero: quotient 0xFFFFFFFF, remainder = dividend; signed 0x80000000/-1: quotient 0x80000000, remainder 0; both resolved combinationally in IDLE, no stall.
REQ-023 Divider SHALL use latched operands only; input changes during BUSY SHALL be ignored.
REQ-024 Back-to-back divides SHALL start the second in the cycle after DONE.

Reset
REQ-025 rst_n low SHALL force FSM to IDLE, clear divider registers, and force E_Stall=0 immediately, including mid-BUSY.
REQ-026 Combinational outputs SHALL follow inputs during reset; no other state exists.

Configuration
REQ-027 Macro EX_STAGE_MULDIV_EN: defined -> REQ-016..024 present; undefined -> no multiplier/divider/FSM logic, E_MulDiv ops yield E_ALUResult=0, E_Stall tied 0.

Verification
REQ-028 ADD RD1=5, RD2=7, ForwardA=10, M_ALUResult=100 -> E_ALUResult=107.
REQ-029 BLT SrcA=0xFFFFFFFF, RD2=1, E_PC=0x100, Imm=0x20 -> E_PCSrc=1, E_PCTarget=0x120; BLTU same -> E_PCSrc=0.
REQ-030 JALR SrcA=0x1003, Imm=4, E_PCPlus4=0x50 -> E_PCTarget=0x1006, E_ALUResult=0x50, E_PCSrc=1.
REQ-031 DIV -7/2 -> E_Stall high 33 cycles, then result 0xFFFFFFFD; REM same -> 0xFFFFFFFF.
REQ-032 DIVU 10/0 -> no stall, 0xFFFFFFFF; REMU 10/0 -> 10; MULH 0x80000000*2 -> 0xFFFFFFFF.
REQ-033 rst_n low at BUSY cycle 10 -> E_Stall=0 at once; after release a new DIVU 100/7 returns 14 after 33 stall cycles.
